// File: rtl/multicore_io_sched_if.sv
// Bundles the sample, core-array and sink buses of the multicore IO scheduler.
// The scheduler is the slave side. The source, cores and sink are the master side.
interface multicore_io_sched_if #(
    parameter int NCORES     = 30,
    parameter int IN_W       = 19,
    parameter int OUT_W      = 28,
    parameter int FIFO_DEPTH = 8
);
    logic signed [IN_W-1:0]        src_data;
    logic                          src_valid;
    logic                          src_ready;
    logic [NCORES-1:0]             req_in;
    logic signed [IN_W-1:0]        core_in_data;
    logic [NCORES-1:0]             core_in_we;
    logic [NCORES*OUT_W-1:0]       core_out_data;
    logic [NCORES-1:0]             core_out_en;
    logic [NCORES-1:0]             core_out_ack;
    logic signed [OUT_W-1:0]       sink_data;
    logic                          sink_valid;
    logic                          sink_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output src_data, src_valid, req_in, core_out_data, core_out_en, sink_ready,
        input  src_ready, core_in_data, core_in_we, core_out_ack, sink_data, sink_valid, fifo_count
    );

    modport slave (
        input  src_data, src_valid, req_in, core_out_data, core_out_en, sink_ready,
        output src_ready, core_in_data, core_in_we, core_out_ack, sink_data, sink_valid, fifo_count
    );
endinterface

// File: rtl/multicore_io_sched.sv
// Round-robin sample distribution to N cores and result collection into an FWFT FIFO.
// Input write lands 1 cycle after transfer. Results are acked the same cycle and stall when the FIFO is full.
module mcio_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic [W-1:0]             head_dat,
    output logic                     head_vld,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign head_vld = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_rdy & head_vld;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module multicore_io_sched #(
    parameter int NCORES     = 30,
    parameter int IN_W       = 19,
    parameter int OUT_W      = 28,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicore_io_sched_if.slave   io
);
    localparam int PW = $clog2(NCORES);
    localparam logic [NCORES-1:0] ONE = {{(NCORES-1){1'b0}}, 1'b1};

    // Returns {found, index} of the first set bit after ptr, wrapping at NCORES.
    function automatic logic [PW:0] rr_pick(input logic [NCORES-1:0] bits,
                                            input logic [PW-1:0]     ptr);
        logic [PW:0]       res;
        logic [NCORES-1:0] sh;
        int                idx;
        res = '0;
        for (int k = NCORES; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NCORES) begin
                idx = idx - NCORES;
            end
            sh = bits >> idx;
            if (sh[0]) begin
                res = {1'b1, idx[PW-1:0]};
            end
        end
        return res;
    endfunction

    logic [NCORES-1:0]       pend;
    logic [PW-1:0]           in_ptr;
    logic [PW-1:0]           out_ptr;
    logic [PW:0]             in_pick;
    logic [PW:0]             out_pick;
    logic [NCORES-1:0]       in_onehot;
    logic [NCORES-1:0]       out_onehot;
    logic                    transfer;
    logic                    out_go;
    logic                    fifo_full;
    logic [NCORES-1:0]       in_we_q;
    logic signed [IN_W-1:0]  in_dat_q;
    logic [OUT_W-1:0]        push_dat;
    logic [OUT_W-1:0]        head_dat;

    // Input side: pending requests are served one per accepted sample.
    assign io.src_ready = |pend;
    assign in_pick      = rr_pick(pend, in_ptr);
    assign in_onehot    = ONE << in_pick[PW-1:0];
    assign transfer     = io.src_valid & in_pick[PW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            in_ptr   <= PW'(NCORES - 1);
            in_we_q  <= '0;
            in_dat_q <= '0;
        end else begin
            // A request arriving with its own grant survives the clear and queues again.
            pend    <= (pend & ~(transfer ? in_onehot : '0)) | io.req_in;
            in_we_q <= transfer ? in_onehot : '0;
            if (transfer) begin
                in_dat_q <= io.src_data;
                in_ptr   <= in_pick[PW-1:0];
            end
        end
    end

    assign io.core_in_we   = in_we_q;
    assign io.core_in_data = in_dat_q;

    // Output side: ack is gated by reset so nothing is taken while the block is held.
    assign out_pick        = rr_pick(io.core_out_en, out_ptr);
    assign out_onehot      = ONE << out_pick[PW-1:0];
    assign out_go          = rst_n & ~fifo_full & out_pick[PW];
    assign io.core_out_ack = out_go ? out_onehot : '0;

    always_comb begin
        push_dat = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (out_pick[PW-1:0] == PW'(i)) begin
                push_dat = io.core_out_data[i*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ptr <= PW'(NCORES - 1);
        end else if (out_go) begin
            out_ptr <= out_pick[PW-1:0];
        end
    end

    mcio_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (out_go),
        .push_dat (push_dat),
        .pop_rdy  (io.sink_ready),
        .head_dat (head_dat),
        .head_vld (io.sink_valid),
        .count    (io.fifo_count),
        .full     (fifo_full)
    );

    assign io.sink_data = head_dat;
endmodule
